split_fork_fifo: RTL and testbench
==================================

Name: split_fork_fifo

Overview:
- Parametrised buffered fork. Accepts a packed word {field_a, field_b} on one valid/ready input and delivers the two fields to two independent valid/ready consumers.
- Replaces the bare concatenated-output child. The two fields stay internal wires of the parent, but each now has its own flow control and a DEPTH-entry buffer.
- An entry retires only once both consumers have taken their field.

Parameters:
A_WIDTH, 8, width of field A (>=1)
B_WIDTH, 8, width of field B (>=1)
DEPTH, 4, buffer entries; power of two, >=2
A_HIGH, 1, 1: field A = in_data upper A_WIDTH bits; 0: field A = lower A_WIDTH bits

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  producer word valid
in_ready  output  1  buffer can accept a word
in_data  input  A_WIDTH+B_WIDTH  packed word
a_valid  output  1  field A of head entry available
a_ready  input  1  consumer A accepts
a_data  output  A_WIDTH  field A of head entry
b_valid  output  1  field B of head entry available
b_ready  input  1  consumer B accepts
b_data  output  B_WIDTH  field B of head entry
count  output  $clog2(DEPTH)+1  occupied entries, 0..DEPTH

Behaviour:
- Storage: circular buffer of DEPTH words. Pointers are $clog2(DEPTH) bits and wrap naturally. count is a separate register.
- Reset (rst=1 at a clock edge) clears pointers, count, a_done and b_done. All in-flight data is discarded.
  - While rst=1: in_ready=0.
  - The cycle after rst deasserts: in_ready=1, a_valid=0, b_valid=0, count=0.
  - a_data and b_data are don't-care while the matching valid is 0.
- Push: in_valid && in_ready. Word is written at the write pointer; the write pointer increments.
- in_ready = !rst && (count != DEPTH). It depends only on registered state, never on a_ready or b_ready. When full, no push occurs even in a cycle that pops.
- Split, with W = A_WIDTH+B_WIDTH:
  - A_HIGH=1: a_data = head[W-1:B_WIDTH], b_data = head[B_WIDTH-1:0].
  - A_HIGH=0: a_data = head[A_WIDTH-1:0], b_data = head[W-1:A_WIDTH].
- Latency: no fall-through. A word pushed at edge t first appears on a_valid/b_valid in the cycle after edge t. Minimum latency is 1 cycle.
- Per-head flags a_done and b_done: set when that consumer's field has been taken but the entry is not yet retired.
  - a_valid = (count!=0) && !a_done.
  - b_valid = (count!=0) && !b_done.
- Handshakes: a_take = a_valid && a_ready; b_take = b_valid && b_ready.
- Pop condition: (a_take || a_done) && (b_take || b_done).
  - On pop: read pointer increments, both flags clear, the next entry is presented the following cycle.
  - Otherwise: a_done |= a_take; b_done |= b_take.
- Consumers may take in the same cycle or in any order, separated by any number of cycles.
- A consumer whose flag is set sees its valid low until the head retires. Its ready is ignored during that time.
- Data stability: a_data and b_data are held stable while the matching valid is high and not taken.
- count update: count_next = count + push - pop.
  - Simultaneous push and pop leaves count unchanged.
  - Pop at count=1 with no push yields count=0 and both valids low.
- Pointer wrap at DEPTH-1 to 0 needs no special handling. Data order is strictly FIFO.
- No overflow or underflow is possible by construction. Optional assertions: never push when count==DEPTH; never pop when count==0.

Test Plan:
- Reset, then DEPTH=4, A_HIGH=1. Push 16'hA55A, both readies held at 1 -> next cycle a_data=8'hA5, b_data=8'h5A, both valids=1; retires that cycle; count 1 -> 0.
- A_HIGH=0, push 16'h1234, b_ready=0 for 3 cycles, a_ready=1 -> A taken on cycle 1, a_valid low for cycles 2-3, b_data=8'h12 stable; entry retires when b_ready=1; count returns to 0.
- Push 5 words 0x0101..0x0505 back-to-back with both readies 0 -> in_ready drops after the 4th push, count=4; 5th word held by producer; raise both readies -> 5th word accepted the cycle after the first pop; output order 01,02,03,04,05 on both channels.
- Full buffer, in_valid=1 and both consumers accept in the same cycle -> no push that cycle, count 4 -> 3; push occurs the next cycle, count back to 4.
- Stream 20 words with random independent a_ready/b_ready -> each channel receives all 20 fields in order; no duplicates or drops across pointer wrap.
- Assert rst mid-stream with count=3 and a_done=1 -> in_ready=0 during reset; the cycle after release count=0, both valids=0; a subsequent push of 16'hBEEF appears one cycle later.

Source files
------------

// File: rtl/split_fork_fifo.sv
// Buffered fork: one valid/ready producer of {field_a, field_b} feeding two
// independent valid/ready consumers; an entry retires once both fields are taken.
module split_fork_fifo #(
    parameter int A_WIDTH = 8,
    parameter int B_WIDTH = 8,
    parameter int DEPTH   = 4,
    parameter bit A_HIGH  = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [A_WIDTH+B_WIDTH-1:0] in_data,
    output logic                       a_valid,
    input  logic                       a_ready,
    output logic [A_WIDTH-1:0]         a_data,
    output logic                       b_valid,
    input  logic                       b_ready,
    output logic [B_WIDTH-1:0]         b_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int W  = A_WIDTH + B_WIDTH;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          a_done;
    logic          b_done;
    logic [W-1:0]  head;

    logic push;
    logic a_take;
    logic b_take;
    logic pop;

    // in_ready looks only at registered state so neither consumer can stall the producer combinationally.
    assign in_ready = !rst && (count_q != CW'(DEPTH));
    assign push     = in_valid && in_ready;

    assign a_valid  = (count_q != '0) && !a_done;
    assign b_valid  = (count_q != '0) && !b_done;
    assign a_take   = a_valid && a_ready;
    assign b_take   = b_valid && b_ready;
    assign pop      = (a_take || a_done) && (b_take || b_done);

    assign head  = mem[rd_ptr];
    assign count = count_q;

    generate
        if (A_HIGH) begin : g_a_high
            assign a_data = head[W-1:B_WIDTH];
            assign b_data = head[B_WIDTH-1:0];
        end else begin : g_a_low
            assign a_data = head[A_WIDTH-1:0];
            assign b_data = head[W-1:A_WIDTH];
        end
    endgenerate

    // NOTE: storage has no reset; stale words are unreachable once pointers and count clear.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            a_done  <= 1'b0;
            b_done  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                a_done <= 1'b0;
                b_done <= 1'b0;
            end else begin
                a_done <= a_done || a_take;
                b_done <= b_done || b_take;
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_split_fork_fifo.sv
// Self-checking bench: two instances (A_HIGH=1 and A_HIGH=0) share stimulus and are
// compared each cycle against a per-consumer queue model.
module tb_split_fork_fifo;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        a_ready;
    logic        b_ready;

    logic        in_ready_h, a_valid_h, b_valid_h;
    logic [7:0]  a_data_h, b_data_h;
    logic [2:0]  count_h;
    logic        in_ready_l, a_valid_l, b_valid_l;
    logic [7:0]  a_data_l, b_data_l;
    logic [2:0]  count_l;

    int n_tests = 0;
    int n_fails = 0;
    int a_recv  = 0;
    int b_recv  = 0;

    // Model: words each consumer has yet to take, oldest first.
    logic [15:0] qa[$];
    logic [15:0] qb[$];

    split_fork_fifo #(.A_WIDTH(8), .B_WIDTH(8), .DEPTH(DEPTH), .A_HIGH(1'b1)) dut_h (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_h), .in_data(in_data),
        .a_valid(a_valid_h), .a_ready(a_ready), .a_data(a_data_h),
        .b_valid(b_valid_h), .b_ready(b_ready), .b_data(b_data_h),
        .count(count_h)
    );

    split_fork_fifo #(.A_WIDTH(8), .B_WIDTH(8), .DEPTH(DEPTH), .A_HIGH(1'b0)) dut_l (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_l), .in_data(in_data),
        .a_valid(a_valid_l), .a_ready(a_ready), .a_data(a_data_l),
        .b_valid(b_valid_l), .b_ready(b_ready), .b_data(b_data_l),
        .count(count_l)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs at the negedge, check both DUTs against the model,
    // advance the model across the posedge and return at the next negedge.
    task automatic step(input logic r, input logic iv, input logic [15:0] d,
                        input logic ar, input logic br, output logic pushed);
        int          na, nb, cnt;
        logic        exp_ir, av, bv;
        logic [15:0] ha, hb;
        rst = r; in_valid = iv; in_data = d; a_ready = ar; b_ready = br;
        #1;
        na = qa.size();
        nb = qb.size();
        cnt = (na > nb) ? na : nb;
        exp_ir = !r && (cnt < DEPTH);
        pushed = iv && exp_ir;
        n_tests++;
        if (in_ready_h !== exp_ir || in_ready_l !== exp_ir) begin
            n_fails++;
            $display("FAIL in_ready: got %b/%b expected %b at %0t", in_ready_h, in_ready_l, exp_ir, $time);
        end
        if (!r) begin
            av = (na > 0) && (na >= nb);
            bv = (nb > 0) && (nb >= na);
            n_tests++;
            if (count_h !== 3'(cnt) || count_l !== 3'(cnt)) begin
                n_fails++;
                $display("FAIL count: got %0d/%0d expected %0d at %0t", count_h, count_l, cnt, $time);
            end
            n_tests++;
            if (a_valid_h !== av || a_valid_l !== av || b_valid_h !== bv || b_valid_l !== bv) begin
                n_fails++;
                $display("FAIL valids: got a=%b/%b b=%b/%b expected a=%b b=%b at %0t",
                         a_valid_h, a_valid_l, b_valid_h, b_valid_l, av, bv, $time);
            end
            if (av) begin
                ha = qa[0];
                n_tests++;
                if (a_data_h !== ha[15:8] || a_data_l !== ha[7:0]) begin
                    n_fails++;
                    $display("FAIL a_data: got %h/%h expected %h/%h at %0t",
                             a_data_h, a_data_l, ha[15:8], ha[7:0], $time);
                end
            end
            if (bv) begin
                hb = qb[0];
                n_tests++;
                if (b_data_h !== hb[7:0] || b_data_l !== hb[15:8]) begin
                    n_fails++;
                    $display("FAIL b_data: got %h/%h expected %h/%h at %0t",
                             b_data_h, b_data_l, hb[7:0], hb[15:8], $time);
                end
            end
            if (av && ar) begin
                void'(qa.pop_front());
                a_recv++;
            end
            if (bv && br) begin
                void'(qb.pop_front());
                b_recv++;
            end
            if (pushed) begin
                qa.push_back(d);
                qb.push_back(d);
            end
        end else begin
            qa.delete();
            qb.delete();
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic ar, input logic br);
        logic p;
        step(1'b0, 1'b0, 16'h0, ar, br, p);
    endtask

    task automatic test_reset();
        logic p;
        step(1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, p);
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, p);
        idle(1'b0, 1'b0);
        n_tests++;
        if (count_h !== 3'd0 || a_valid_h !== 1'b0 || b_valid_h !== 1'b0 || in_ready_h !== 1'b1) begin
            n_fails++;
            $display("FAIL reset_state: count=%0d av=%b bv=%b ir=%b expected 0 0 0 1",
                     count_h, a_valid_h, b_valid_h, in_ready_h);
        end
    endtask

    task automatic test_pass_through();
        logic p;
        step(1'b0, 1'b1, 16'hA55A, 1'b1, 1'b1, p);
        n_tests++;
        if (a_valid_h !== 1'b1 || b_valid_h !== 1'b1 || a_data_h !== 8'hA5 || b_data_h !== 8'h5A
            || count_h !== 3'd1) begin
            n_fails++;
            $display("FAIL pass_through: av=%b bv=%b a=%h b=%h count=%0d expected 1 1 a5 5a 1",
                     a_valid_h, b_valid_h, a_data_h, b_data_h, count_h);
        end
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, p);
        n_tests++;
        if (count_h !== 3'd0 || a_valid_h !== 1'b0) begin
            n_fails++;
            $display("FAIL pass_through_retire: count=%0d av=%b expected 0 0", count_h, a_valid_h);
        end
    endtask

    task automatic test_b_backpressure();
        logic p;
        step(1'b0, 1'b1, 16'h1234, 1'b1, 1'b0, p);
        n_tests++;
        if (a_data_l !== 8'h34 || a_valid_l !== 1'b1) begin
            n_fails++;
            $display("FAIL bp_a_first: a=%h av=%b expected 34 1", a_data_l, a_valid_l);
        end
        for (int i = 0; i < 3; i++) begin
            idle(1'b1, 1'b0);
            n_tests++;
            if (a_valid_l !== 1'b0 || b_valid_l !== 1'b1 || b_data_l !== 8'h12 || count_l !== 3'd1) begin
                n_fails++;
                $display("FAIL bp_hold[%0d]: av=%b bv=%b b=%h count=%0d expected 0 1 12 1",
                         i, a_valid_l, b_valid_l, b_data_l, count_l);
            end
        end
        idle(1'b1, 1'b1);
        n_tests++;
        if (count_l !== 3'd0 || b_valid_l !== 1'b0) begin
            n_fails++;
            $display("FAIL bp_retire: count=%0d bv=%b expected 0 0", count_l, b_valid_l);
        end
    endtask

    task automatic test_full();
        logic p;
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b1, {8'(i), 8'(i)}, 1'b0, 1'b0, p);
        end
        n_tests++;
        if (count_h !== 3'd4 || in_ready_h !== 1'b0) begin
            n_fails++;
            $display("FAIL full: count=%0d ir=%b expected 4 0", count_h, in_ready_h);
        end
        // 5th word offered while full and both consumers take: pop only.
        step(1'b0, 1'b1, 16'h0505, 1'b1, 1'b1, p);
        n_tests++;
        if (p !== 1'b0 || count_h !== 3'd3 || in_ready_h !== 1'b1) begin
            n_fails++;
            $display("FAIL full_pop: pushed=%b count=%0d ir=%b expected 0 3 1", p, count_h, in_ready_h);
        end
        step(1'b0, 1'b1, 16'h0505, 1'b0, 1'b0, p);
        n_tests++;
        if (p !== 1'b1 || count_h !== 3'd4) begin
            n_fails++;
            $display("FAIL full_refill: pushed=%b count=%0d expected 1 4", p, count_h);
        end
        for (int i = 0; i < 5; i++) idle(1'b1, 1'b1);
    endtask

    task automatic test_random_stream();
        int          sent = 0;
        int          budget = 0;
        int          a0, b0;
        logic        p, iv;
        logic [15:0] w;
        a0 = a_recv;
        b0 = b_recv;
        w  = 16'($urandom);
        while ((a_recv - a0 < 20 || b_recv - b0 < 20) && budget < 1000) begin
            iv = (sent < 20) && ($urandom_range(0, 3) != 0);
            step(1'b0, iv, w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), p);
            if (p) begin
                sent++;
                w = 16'($urandom);
            end
            budget++;
        end
        n_tests++;
        if (a_recv - a0 != 20 || b_recv - b0 != 20 || qa.size() != 0 || qb.size() != 0) begin
            n_fails++;
            $display("FAIL random_stream: a got %0d b got %0d expected 20 20 (cycles %0d)",
                     a_recv - a0, b_recv - b0, budget);
        end
    endtask

    task automatic test_reset_mid();
        logic p;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h1111 * (i + 1), 1'b0, 1'b0, p);
        idle(1'b1, 1'b0);
        n_tests++;
        if (count_h !== 3'd3 || a_valid_h !== 1'b0 || b_valid_h !== 1'b1) begin
            n_fails++;
            $display("FAIL mid_pre: count=%0d av=%b bv=%b expected 3 0 1", count_h, a_valid_h, b_valid_h);
        end
        step(1'b1, 1'b1, 16'h5555, 1'b0, 1'b0, p);
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, p);
        idle(1'b0, 1'b0);
        n_tests++;
        if (count_h !== 3'd0 || a_valid_h !== 1'b0 || b_valid_h !== 1'b0 || in_ready_h !== 1'b1) begin
            n_fails++;
            $display("FAIL mid_post: count=%0d av=%b bv=%b ir=%b expected 0 0 0 1",
                     count_h, a_valid_h, b_valid_h, in_ready_h);
        end
        step(1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0, p);
        n_tests++;
        if (a_valid_h !== 1'b1 || a_data_h !== 8'hBE || b_data_h !== 8'hEF || a_data_l !== 8'hEF) begin
            n_fails++;
            $display("FAIL mid_beef: av=%b a=%h b=%h al=%h expected 1 be ef ef",
                     a_valid_h, a_data_h, b_data_h, a_data_l);
        end
        idle(1'b1, 1'b1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; a_ready = 1'b0; b_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_pass_through();
        test_b_backpressure();
        test_full();
        test_random_stream();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
